truth_table_checker: RTL

- Hardware stimulus/response engine for 3-input combinational blocks.
- Drives all 8 {a,b,c} vectors in ascending order, each held for HOLD_CYCLES clocks.
- Samples the DUT output y_in at the end of each hold window and assembles an 8-bit captured truth table.
- Compares that table against EXPECTED and reports pass/fail plus the lowest failing vector index. Used for on-chip self-check of small gate-level circuits.

---
 rtl/truth_table_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Stimulus/response engine: walks {a,b,c} through 0..7, samples y_in at the end of
// each hold window and grades the captured truth table. Optional macro: TTC_EARLY_ABORT_EN.
module truth_table_checker #(
    parameter int          HOLD_CYCLES = 20,
    parameter logic [7:0]  EXPECTED    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] captured_q, captured_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] failIdx_q, failIdx_d;
    logic [7:0] finalCap;
    logic       abortNow;

    function automatic logic [2:0] lowestMismatch(input logic [7:0] diff);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

`ifdef TTC_EARLY_ABORT_EN
    assign abortNow = (y_in != EXPECTED[vec_q]);
`else
    assign abortNow = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= 3'd0;
            cnt_q      <= 8'd0;
            captured_q <= 8'd0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failIdx_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            failIdx_q  <= failIdx_d;
        end
    end

    // finalCap is the table as it will look once the current sample lands; the
    // verdict on the last vector is graded from it so it registers with the DONE entry.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        done_d     = done_q;
        pass_d     = pass_q;
        failIdx_d  = failIdx_q;
        finalCap   = captured_q;
        finalCap[vec_q] = y_in;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = DRIVE;
                    vec_d      = 3'd0;
                    cnt_d      = 8'd0;
                    captured_d = 8'd0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    failIdx_d  = 3'd0;
                end
            end
            DRIVE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 8'd0;
                    if (abortNow) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                        failIdx_d = vec_q;
                    end else begin
                        captured_d = finalCap;
                        if (vec_q == 3'd7) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            pass_d    = (finalCap == EXPECTED);
                            failIdx_d = lowestMismatch(finalCap ^ EXPECTED);
                        end else begin
                            vec_d = vec_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {a_out, b_out, c_out} = vec_q;
    assign busy     = (state_q == DRIVE);
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
    assign fail_idx = failIdx_q;

endmodule
